// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front-end for MainMemory.
// Accepts one line read/write at a time, drives it onto the memory port,
// captures the read result after RD_LAT cycles and returns a response to
// the requester that won the grant.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; req_ready offered to the grant winner
// WRITE   | one-cycle write pulse on the memory port
// RD_WAIT | address held on the memory port while read latency elapses
// RESP    | response held to the owner until it raises rsp_ready
module mem_req_arbiter #(
    parameter int PAGE_W = 1,
    parameter int CODE_W = 8,
    parameter int DATA_W = 64,
    parameter int MESI_W = 2,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*PAGE_W-1:0] req_page,
    input  logic [2*CODE_W-1:0] req_code,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [2*MESI_W-1:0] req_mesi,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [MESI_W-1:0]   rsp_mesi,
    output logic [PAGE_W-1:0]   mem_page,
    output logic [CODE_W-1:0]   mem_code,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [MESI_W-1:0]   mem_mesi_in,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [MESI_W-1:0]   mem_mesi_out
);

    // RD_LAT is bounded to 1..15, so a 4-bit down-counter covers it.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MESI_W-1:0]   mesi_q, mesi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [MESI_W-1:0]   rsp_mesi_q, rsp_mesi_d;

    logic                grant;
    logic                grant_ok;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_valid[1];
        end
        grant_ok = req_valid[grant];
    end

    // Next-state decision for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d = req_we[grant] ? WRITE : RD_WAIT;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RD_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and response capture.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        page_d       = page_q;
        code_d       = code_q;
        wdata_d      = wdata_q;
        mesi_d       = mesi_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_mesi_d   = rsp_mesi_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    last_grant_d = grant;
                    owner_d      = grant;
                    we_d         = req_we[grant];
                    page_d       = grant ? req_page[2*PAGE_W-1:PAGE_W]   : req_page[PAGE_W-1:0];
                    code_d       = grant ? req_code[2*CODE_W-1:CODE_W]   : req_code[CODE_W-1:0];
                    wdata_d      = grant ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
                    mesi_d       = grant ? req_mesi[2*MESI_W-1:MESI_W]   : req_mesi[MESI_W-1:0];
                    cnt_d        = CNT_W'(RD_LAT);
                end
            end
            WRITE: begin
                // A write response echoes what was stored.
                rsp_data_d = wdata_q;
                rsp_mesi_d = mesi_q;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d = mem_rdata;
                    rsp_mesi_d = mem_mesi_out;
                end
            end
            default: begin
            end
        endcase
    end

    // Handshake and memory-port outputs. req_ready is masked by reset so
    // nothing is offered while the block is held in reset.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (state_q == IDLE && grant_ok && reset) begin
            req_ready[grant] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
        mem_we      = (state_q == WRITE);
        mem_page    = page_q;
        mem_code    = code_q;
        mem_wdata   = wdata_q;
        mem_mesi_in = mesi_q;
        rsp_data    = rsp_data_q;
        rsp_mesi    = rsp_mesi_q;
    end

    // State and datapath registers; last_grant resets to 1 so requester 0
    // wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            page_q       <= '0;
            code_q       <= '0;
            wdata_q      <= '0;
            mesi_q       <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_mesi_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            page_q       <= page_d;
            code_q       <= code_d;
            wdata_q      <= wdata_d;
            mesi_q       <= mesi_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_mesi_q   <= rsp_mesi_d;
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Upstream front-end for MainMemory: arbitrates line read/write requests from two cache-side requesters (round-robin).
- Sequences each winning request onto the memory port (addr, wdata, we, mesi_state_in).
- Captures read data and MESI state after a configurable read latency, then returns a response to the winner.
- One outstanding request at a time; sits between the L1 miss/writeback logic and MainMemory.

Parameters:
- PAGE_W, 1, width of Page_reference field.
- CODE_W, 8, width of Address_code field.
- DATA_W, 64, width of data word (Tdata_sb.Data).
- MESI_W, 2, width of MESI state encoding.
- RD_LAT, 1, cycles from address presentation to valid mem_rdata (legal range 1..15).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a request transfers when valid&ready.
- req_we  in  2  per-requester: 1 = write, 0 = read.
- req_page  in  2*PAGE_W  per-requester page reference (requester i at slice i).
- req_code  in  2*CODE_W  per-requester address code.
- req_wdata  in  2*DATA_W  per-requester write data.
- req_mesi  in  2*MESI_W  per-requester MESI state to store on write.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  read data (write: echoed write data).
- rsp_mesi  out  MESI_W  MESI state read (write: echoed stored state).
- mem_page  out  PAGE_W  to MainMemory addr.Page_reference.
- mem_code  out  CODE_W  to MainMemory addr.Address_code.
- mem_wdata  out  DATA_W  to MainMemory wdata.Data.
- mem_we  out  1  to MainMemory we.
- mem_mesi_in  out  MESI_W  to MainMemory mesi_state_in.
- mem_rdata  in  DATA_W  from MainMemory rdata.Data.
- mem_mesi_out  in  MESI_W  from MainMemory mesi_state_out.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0 (req_ready, rsp_valid, mem_we, mem_page, mem_code, mem_wdata, mem_mesi_in, rsp_data, rsp_mesi).
  - last_grant=1, so requester 0 wins first contention.
- States: IDLE, WRITE, RD_WAIT, RESP.
- IDLE:
  - req_ready is combinational: req_ready[g]=1 only for the granted requester g, and only when req_valid[g]=1; the other bit is 0.
  - Grant rule: only one valid -> that one; both valid -> the one != last_grant.
  - On transfer: latch page/code/wdata/mesi/we and owner=g; last_grant<=g.
  - Next state: WRITE if we=1, else RD_WAIT with cnt<=RD_LAT.
  - No valid -> stay IDLE.
- WRITE (1 cycle):
  - mem_we=1; mem_page/code/wdata/mesi_in = latched values.
  - rsp_data<=wdata, rsp_mesi<=mesi; -> RESP.
- RD_WAIT:
  - mem_we=0; address held on mem_page/mem_code; cnt decrements each cycle.
  - When cnt==1: rsp_data<=mem_rdata, rsp_mesi<=mem_mesi_out; -> RESP.
  - Total RD_WAIT occupancy = RD_LAT cycles.
- RESP:
  - rsp_valid[owner]=1, other bit 0; rsp_data and rsp_mesi held stable.
  - rsp_ready[owner]=1 -> IDLE on next edge. rsp_ready of the non-owner is ignored.
- Memory address outputs hold their last value outside active states. mem_we is 1 only in WRITE.
- req_ready=0 in all states except IDLE; new requests wait, no queuing.
- Latency:
  - Write: accept -> rsp_valid 2 cycles later.
  - Read: accept -> rsp_valid RD_LAT+1 cycles later.
  - Minimum cycle spacing between accepts: write 3, read RD_LAT+2.
- Requester dropping req_valid before acceptance: no effect, nothing latched.
- Reset asserted mid-transaction: transaction abandoned, no response issued, mem_we drops to 0 immediately (async).

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=2'b11 -> all outputs 0, req_ready=2'b00; release -> first cycle req_ready=2'b01.
- Write then read, requester 0: write page=1 code=8'h2A wdata=64'hDEADBEEF_01234567 mesi=2'b00 -> mem_we=1 exactly one cycle, rsp_valid=2'b01 two cycles after accept. Then read same address -> rsp_data=64'hDEADBEEF_01234567, rsp_mesi=2'b00, RD_LAT+1 cycles after accept.
- Contention: both requesters valid continuously, all reads -> grants alternate 0,1,0,1; each rsp_valid goes only to its owner.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_data stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- RD_LAT=3 build: read page=0 code=8'hFF -> mem_we=0, address stable 3 cycles, rsp_valid 4 cycles after accept.
- Mid-read reset: assert reset in RD_WAIT -> rsp_valid never asserts, state IDLE; next request served normally.
